// File: rtl/regfile_access_arbiter.sv
// Arbitrates the single-port register file between decode reads and writeback writes.
// Writes win by default; a starvation counter forces a read through unless it would pass a RAW hazard.
module regfile_access_arbiter #(
    parameter  int unsigned MAX_WAIT = 4,
    parameter  int unsigned CNT_W    = 3,
    localparam int unsigned OP_W     = 6,
    localparam int unsigned IDX_W    = 5,
    localparam int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reg_reset,
    input  logic              rd_req,
    input  logic [OP_W-1:0]   rd_opcode,
    input  logic [IDX_W-1:0]  rd_reg1,
    input  logic [IDX_W-1:0]  rd_reg2,
    input  logic [IDX_W-1:0]  rd_reg3,
    input  logic [DATA_W-1:0] rd_imm,
    output logic              rd_ack,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [OP_W-1:0]   wr_opcode,
    input  logic [IDX_W-1:0]  wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              reg_read,
    output logic              reg_write,
    output logic [OP_W-1:0]   opcode,
    output logic [IDX_W-1:0]  reg1,
    output logic [IDX_W-1:0]  reg2,
    output logic [IDX_W-1:0]  reg3,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] write_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_DONE  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [IDX_W-1:0]  reg1;
        logic [IDX_W-1:0]  reg2;
        logic [IDX_W-1:0]  reg3;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] write_data;
    } rf_cmd_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    rf_cmd_t           cmd_q, cmd_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_ack_q, wr_ack_d;
    logic              reg_read_q, reg_read_d;
    logic              reg_write_q, reg_write_d;

    logic              hazard_c;
    logic              starved_c;
    logic              read_wins_c;

    // A pending write to any register the read will source must land first.
    assign hazard_c    = wr_req & ((wr_reg == rd_reg1) | (wr_reg == rd_reg2) | (wr_reg == rd_reg3));
    assign starved_c   = (starve_cnt_q >= CNT_W'(MAX_WAIT));
    assign read_wins_c = rd_req & (~wr_req | (starved_c & ~hazard_c));

    // Outputs are computed for the state being entered, so they appear with it.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        cmd_d        = cmd_q;
        rd_ack_d     = 1'b0;
        rd_valid_d   = 1'b0;
        wr_ack_d     = 1'b0;
        reg_read_d   = 1'b0;
        reg_write_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_wins_c) begin
                    state_d      = RD_ISSUE;
                    reg_read_d   = 1'b1;
                    rd_ack_d     = 1'b1;
                    starve_cnt_d = '0;
                    cmd_d.opcode = rd_opcode;
                    cmd_d.reg1   = rd_reg1;
                    cmd_d.reg2   = rd_reg2;
                    cmd_d.reg3   = rd_reg3;
                    cmd_d.imm    = rd_imm;
                end else if (wr_req) begin
                    state_d          = WR_ISSUE;
                    reg_write_d      = 1'b1;
                    wr_ack_d         = 1'b1;
                    cmd_d.opcode     = wr_opcode;
                    cmd_d.reg1       = wr_reg;
                    cmd_d.write_data = wr_data;
                    if (!rd_req) begin
                        starve_cnt_d = '0;
                    end else if (!starved_c) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end
            end
            RD_ISSUE: begin
                state_d    = RD_DONE;
                rd_valid_d = 1'b1;
            end
            RD_DONE:  state_d = IDLE;
            WR_ISSUE: state_d = WR_DONE;
            WR_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reg_reset) begin
        if (reg_reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            cmd_q        <= '0;
            rd_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            reg_read_q   <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            cmd_q        <= cmd_d;
            rd_ack_q     <= rd_ack_d;
            rd_valid_q   <= rd_valid_d;
            wr_ack_q     <= wr_ack_d;
            reg_read_q   <= reg_read_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign rd_ack     = rd_ack_q;
    assign rd_valid   = rd_valid_q;
    assign wr_ack     = wr_ack_q;
    assign reg_read   = reg_read_q;
    assign reg_write  = reg_write_q;
    assign opcode     = cmd_q.opcode;
    assign reg1       = cmd_q.reg1;
    assign reg2       = cmd_q.reg2;
    assign reg3       = cmd_q.reg3;
    assign imm        = cmd_q.imm;
    assign write_data = cmd_q.write_data;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios with literal expectations, then random
// request traffic checked every cycle against a transaction-level reference model.
module tb_regfile_access_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reg_reset;
    logic        rd_req;
    logic [5:0]  rd_opcode;
    logic [4:0]  rd_reg1, rd_reg2, rd_reg3;
    logic [31:0] rd_imm;
    logic        rd_ack, rd_valid;
    logic        wr_req;
    logic [5:0]  wr_opcode;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        wr_ack, reg_read, reg_write;
    logic [5:0]  opcode;
    logic [4:0]  reg1, reg2, reg3;
    logic [31:0] imm, write_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    regfile_access_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk(clk), .reg_reset(reg_reset),
        .rd_req(rd_req), .rd_opcode(rd_opcode), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rd_reg3(rd_reg3), .rd_imm(rd_imm), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_opcode(wr_opcode), .wr_reg(wr_reg), .wr_data(wr_data),
        .wr_ack(wr_ack), .reg_read(reg_read), .reg_write(reg_write), .opcode(opcode),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .imm(imm), .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: an access occupies three cycles from its grant; m_age counts cycles since it.
    int          m_age = 3;
    bit          m_is_rd = 1'b0;
    int          m_starve = 0;
    logic [5:0]  m_opcode = '0;
    logic [4:0]  m_reg1 = '0, m_reg2 = '0, m_reg3 = '0;
    logic [31:0] m_imm = '0, m_wdata = '0;

    function automatic bit model_read_wins();
        bit hz;
        hz = wr_req && (wr_reg == rd_reg1 || wr_reg == rd_reg2 || wr_reg == rd_reg3);
        return rd_req && (!wr_req || (m_starve == MAX_WAIT && !hz));
    endfunction

    always @(posedge clk or posedge reg_reset) begin
        if (reg_reset) begin
            m_age <= 3; m_is_rd <= 1'b0; m_starve <= 0;
            m_opcode <= '0; m_reg1 <= '0; m_reg2 <= '0; m_reg3 <= '0; m_imm <= '0; m_wdata <= '0;
        end else if (m_age >= 3) begin
            if (model_read_wins()) begin
                m_age <= 1; m_is_rd <= 1'b1; m_starve <= 0;
                m_opcode <= rd_opcode; m_reg1 <= rd_reg1; m_reg2 <= rd_reg2;
                m_reg3 <= rd_reg3; m_imm <= rd_imm;
            end else if (wr_req) begin
                m_age <= 1; m_is_rd <= 1'b0;
                m_starve <= !rd_req ? 0 : (m_starve < MAX_WAIT ? m_starve + 1 : MAX_WAIT);
                m_opcode <= wr_opcode; m_reg1 <= wr_reg; m_wdata <= wr_data;
            end
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("excl_rd_wr", 32'(reg_read & reg_write), 32'd0);
            check("m_rd_ack",    32'(rd_ack),    32'(m_age == 1 && m_is_rd));
            check("m_reg_read",  32'(reg_read),  32'(m_age == 1 && m_is_rd));
            check("m_rd_valid",  32'(rd_valid),  32'(m_age == 2 && m_is_rd));
            check("m_wr_ack",    32'(wr_ack),    32'(m_age == 1 && !m_is_rd));
            check("m_reg_write", 32'(reg_write), 32'(m_age == 1 && !m_is_rd));
            check("m_opcode", 32'(opcode), 32'(m_opcode));
            check("m_reg1",   32'(reg1),   32'(m_reg1));
            check("m_reg2",   32'(reg2),   32'(m_reg2));
            check("m_reg3",   32'(reg3),   32'(m_reg3));
            check("m_imm",    imm,         m_imm);
            check("m_wdata",  write_data,  m_wdata);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rd(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] r3, input logic [31:0] im);
        rd_req = 1'b1; rd_opcode = op; rd_reg1 = r1; rd_reg2 = r2; rd_reg3 = r3; rd_imm = im;
    endtask

    task automatic set_wr(input logic [5:0] op, input logic [4:0] r, input logic [31:0] d);
        wr_req = 1'b1; wr_opcode = op; wr_reg = r; wr_data = d;
    endtask

    // Writes stream continuously while a read waits; returns writes granted before the read.
    task automatic write_stream(input bit hazard_reg, input int drop_after, output int writes,
                                output int read_wait);
        int n;
        bit got_rd;
        writes = 0; read_wait = -1; got_rd = 1'b0;
        set_rd(6'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        set_wr(6'd1, hazard_reg ? 5'd2 : 5'd8, $urandom);
        n = 0;
        while (!got_rd && n < 80) begin
            @(negedge clk);
            n++;
            if (wr_ack) begin
                writes++;
                if (drop_after > 0 && writes == drop_after) begin
                    wr_req = 1'b0; n = 0;
                end else begin
                    set_wr(6'd1, hazard_reg ? 5'd2 : 5'(8 + writes % 8), $urandom);
                end
            end
            if (rd_ack) begin
                got_rd = 1'b1; read_wait = n; rd_req = 1'b0; wr_req = 1'b0;
            end
        end
        if (!got_rd) check("stream_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int w, rw;
        reg_reset = 1'b1;
        rd_req = 1'b0; rd_opcode = '0; rd_reg1 = '0; rd_reg2 = '0; rd_reg3 = '0; rd_imm = '0;
        wr_req = 1'b0; wr_opcode = '0; wr_reg = '0; wr_data = '0;
        cyc(2);
        check("rst_rd_ack", 32'(rd_ack), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_strobes", 32'({reg_read, reg_write}), 32'd0);
        check("rst_fields", 32'(opcode) | 32'(reg1) | 32'(reg2) | 32'(reg3) | imm | write_data, 32'd0);
        reg_reset = 1'b0;
        chk_en = 1'b1;

        // Plain read: ack one cycle after the request, operands valid the cycle after that.
        cyc(1);
        set_rd(6'b000000, 5'd3, 5'd4, 5'd5, 32'hCAFE_0001);
        cyc(1);
        check("t1_rd_ack", 32'(rd_ack), 32'd1);
        check("t1_reg_read", 32'(reg_read), 32'd1);
        check("t1_regs", 32'({reg1, reg2, reg3}), 32'({5'd3, 5'd4, 5'd5}));
        check("t1_valid_early", 32'(rd_valid), 32'd0);
        rd_req = 1'b0;
        cyc(1);
        check("t1_rd_valid", 32'(rd_valid), 32'd1);
        check("t1_read_drop", 32'(reg_read), 32'd0);
        cyc(1);
        check("t1_valid_drop", 32'(rd_valid), 32'd0);

        // Plain write.
        set_wr(6'b010000, 5'd7, 32'h0000_1234);
        cyc(1);
        check("t2_wr_ack", 32'(wr_ack), 32'd1);
        check("t2_reg_write", 32'(reg_write), 32'd1);
        check("t2_fields", 32'({opcode, reg1}), 32'({6'b010000, 5'd7}));
        check("t2_wdata", write_data, 32'h0000_1234);
        check("t2_regs_hold", 32'({reg2, reg3}), 32'({5'd4, 5'd5}));
        wr_req = 1'b0;
        cyc(1);
        check("t2_write_drop", 32'(reg_write), 32'd0);
        cyc(1);

        // Simultaneous requests without hazard: write first, read granted three cycles later.
        set_rd(6'd2, 5'd1, 5'd2, 5'd3, 32'h55);
        set_wr(6'd3, 5'd9, 32'hBEEF);
        cyc(1);
        check("t3_wr_first", 32'({wr_ack, rd_ack}), 32'b10);
        wr_req = 1'b0;
        cyc(2);
        check("t3_rd_not_yet", 32'(rd_ack), 32'd0);
        cyc(1);
        check("t3_rd_ack", 32'(rd_ack), 32'd1);
        check("t3_reg1", 32'(reg1), 32'd1);
        rd_req = 1'b0;
        cyc(3);

        // Starvation bound: four writes then the read; a second round shows the count restarted.
        for (int r = 0; r < 2; r++) begin
            write_stream(1'b0, 0, w, rw);
            check("t4_writes_before_read", 32'(w), 32'd4);
            cyc(3);
        end

        // Hazard: the read is never forced past writes to r2, only granted once writes stop.
        write_stream(1'b1, 8, w, rw);
        check("t5_writes", 32'(w), 32'd8);
        check("t5_read_after_drop", 32'(rw), 32'd3);
        cyc(3);

        // Reset in the middle of a read issue.
        set_rd(6'd4, 5'd10, 5'd11, 5'd12, 32'h77);
        @(posedge clk);
        #1;
        check("t6_issue", 32'(reg_read), 32'd1);
        #1 reg_reset = 1'b1;
        #1;
        check("t6_async_drop", 32'({reg_read, rd_ack, rd_valid, reg_write, wr_ack}), 32'd0);
        check("t6_fields_zero", 32'(reg1) | 32'(opcode) | imm, 32'd0);
        rd_req = 1'b0;
        cyc(1);
        reg_reset = 1'b0;
        cyc(1);
        check("t6_no_valid", 32'(rd_valid), 32'd0);
        set_rd(6'd4, 5'd10, 5'd11, 5'd12, 32'h77);
        cyc(1);
        check("t6_idle_regrant", 32'(rd_ack), 32'd1);
        rd_req = 1'b0;
        cyc(3);
        check("model_starve_idle", 32'(m_starve), 32'd0);

        // Random traffic with small register ranges so hazards and starvation both occur.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (reg_reset) begin
                reg_reset = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                reg_reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
            end else begin
                if (rd_ack) rd_req = 1'b0;
                else if (!rd_req && $urandom_range(0, 2) == 0)
                    set_rd(6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), $urandom);
                if (wr_ack) wr_req = 1'b0;
                else if (!wr_req && $urandom_range(0, 3) != 0)
                    set_wr(6'($urandom), 5'($urandom_range(0, 11)), $urandom);
            end
        end
        rd_req = 1'b0; wr_req = 1'b0; reg_reset = 1'b0;
        cyc(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
